// File: rtl/audio_pkg.sv
// Shared audio types and I2S timing constants for note_gen and i2s_speaker_ctrl.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package audio_pkg;
  localparam int SAMPLE_W     = 16;
  localparam int I2S_CNT_W    = 9;
  localparam int I2S_MCLK_BIT = 1;
  localparam int I2S_SCK_BIT  = 3;
  // One slot per SCK period; 2*SAMPLE_W slots per frame.
  localparam int I2S_SLOT_W   = I2S_CNT_W - 1 - I2S_SCK_BIT;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Bit carried in slot s (1..31) of the frame word {left,right}: F[32-s].
  // 32-s is taken modulo 32, which equals the two's complement of s.
  function automatic logic frame_bit(input logic [2*SAMPLE_W-1:0] f,
                                     input logic [I2S_SLOT_W-1:0] s);
    logic [I2S_SLOT_W-1:0] idx;
    idx = '0 - s;
    return f[idx];
  endfunction
endpackage

// File: rtl/i2s_speaker_ctrl_if.sv
// Sample input and DAC pin bundle between the sample source and i2s_speaker_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; samples are sampled once per frame, the source just holds them.
interface i2s_speaker_ctrl_if;
  import audio_pkg::*;

  sample_t audio_left;
  sample_t audio_right;
  logic    mute;
  logic    audio_mclk;
  logic    audio_lrck;
  logic    audio_sck;
  logic    audio_sdin;
  logic    sample_tick;

  // Sample source side (note_gen or a bench).
  modport master (
    output audio_left, audio_right, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
  );

  // I2S controller side.
  modport slave (
    input  audio_left, audio_right, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
  );
endinterface

// File: rtl/audio_clk_div.sv
// Free-running frame counter with MCLK/SCK/LRCK taps and frame/slot strobes.
// Latency: clock taps come straight from counter flops; strobes are combinational.
// Backpressure: none; the counter never stalls.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int CNT_W    = I2S_CNT_W,
  parameter int MCLK_BIT = I2S_MCLK_BIT,
  parameter int SCK_BIT  = I2S_SCK_BIT
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mclk_o,
  output logic                    sck_o,
  output logic                    lrck_o,
  output logic                    frame_start_o, // next edge wraps cnt to 0
  output logic                    slot_start_o,  // next edge starts a new slot
  output logic [CNT_W-2-SCK_BIT:0] slot_nxt_o    // slot index after next edge
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: plain wrap-around increment.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register, cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign mclk_o        = cnt_q[MCLK_BIT];
  assign sck_o         = cnt_q[SCK_BIT];
  assign lrck_o        = cnt_q[CNT_W-1];
  assign frame_start_o = &cnt_q;
  assign slot_start_o  = &cnt_q[SCK_BIT:0];
  assign slot_nxt_o    = cnt_d[CNT_W-1:SCK_BIT+1];
endmodule

// File: rtl/i2s_speaker_ctrl.sv
// Latches a stereo PCM pair per frame and serializes it to an I2S DAC, MSB first.
// Latency: sample latched at the frame wrap edge; its MSB is sampled by the DAC 24 clk later.
// Backpressure: none; inputs are sampled only at the frame wrap, sample_tick marks it.
module i2s_speaker_ctrl
  import audio_pkg::*;
#(
  parameter int CNT_W    = I2S_CNT_W,
  parameter int MCLK_BIT = I2S_MCLK_BIT,
  parameter int SCK_BIT  = I2S_SCK_BIT
) (
  input  logic               clk,
  input  logic               rst,
  i2s_speaker_ctrl_if.slave  spk
);
  localparam int SLOT_W = CNT_W - 1 - SCK_BIT;

  logic              mclk, sck, lrck;
  logic              frame_start, slot_start;
  logic [SLOT_W-1:0] slot_nxt;

  sample_t hold_l_q, hold_l_d;
  sample_t hold_r_q, hold_r_d;
  logic    prev_lsb_q, prev_lsb_d;
  logic    sdin_q, sdin_d;
  logic    tick_q, tick_d;
  logic    started_q;

  audio_clk_div #(
    .CNT_W    (CNT_W),
    .MCLK_BIT (MCLK_BIT),
    .SCK_BIT  (SCK_BIT)
  ) u_clk_div (
    .clk           (clk),
    .rst           (rst),
    .mclk_o        (mclk),
    .sck_o         (sck),
    .lrck_o        (lrck),
    .frame_start_o (frame_start),
    .slot_start_o  (slot_start),
    .slot_nxt_o    (slot_nxt)
  );

  // Frame latch and serializer next state; the sdin flop moves only at slot boundaries.
  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    prev_lsb_d = prev_lsb_q;
    sdin_d     = sdin_q;
    // The first edge after reset release also pulses the tick: a fresh frame began at release.
    tick_d     = frame_start | ~started_q;
    if (frame_start) begin
      hold_l_d   = spk.mute ? '0 : spk.audio_left;
      hold_r_d   = spk.mute ? '0 : spk.audio_right;
      prev_lsb_d = hold_r_q[0];
    end
    if (slot_start) begin
      if (slot_nxt == '0) sdin_d = prev_lsb_d;
      else                sdin_d = frame_bit({hold_l_d, hold_r_d}, slot_nxt);
    end
  end

  // State registers, all cleared by the async reset so every output drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      prev_lsb_q <= 1'b0;
      sdin_q     <= 1'b0;
      tick_q     <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      prev_lsb_q <= prev_lsb_d;
      sdin_q     <= sdin_d;
      tick_q     <= tick_d;
      started_q  <= 1'b1;
    end
  end

  assign spk.audio_mclk  = mclk;
  assign spk.audio_sck   = sck;
  assign spk.audio_lrck  = lrck;
  assign spk.audio_sdin  = sdin_q;
  assign spk.sample_tick = tick_q;
endmodule

// File: tb/tb_i2s_speaker_ctrl.sv
// Bench for i2s_speaker_ctrl: directed and random sample streams, decoded like a DAC.
// Latency: frames are decoded on SCK rising and compared one frame after latch.
// Backpressure: none.
module tb_i2s_speaker_ctrl;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2s_speaker_ctrl_if spk();

  i2s_speaker_ctrl dut (
    .clk (clk),
    .rst (rst),
    .spk (spk)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n;            // clk edges since reset release
  int          lrck_rise_n;
  logic        lrck_prev;
  logic        sdin_start;
  logic [31:0] dec;
  logic [31:0] exp_q[$];     // expected {L,R} per frame, oldest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input sample_t l, input sample_t r, input logic m);
    spk.audio_left  = l;
    spk.audio_right = r;
    spk.mute        = m;
  endtask

  // One clk: capture what the DUT may latch, advance, then check pins and decode SDIN.
  task automatic step();
    logic [31:0] cap;
    int          c;
    int          s;
    cap = spk.mute ? 32'h0 : {spk.audio_left, spk.audio_right};
    @(posedge clk);
    #1;
    n++;
    c = n % 512;
    chk("mclk", 32'(spk.audio_mclk), 32'((c % 4) >= 2));
    chk("sck",  32'(spk.audio_sck),  32'((c % 16) >= 8));
    chk("lrck", 32'(spk.audio_lrck), 32'(c >= 256));
    chk("sample_tick", 32'(spk.sample_tick), 32'((c == 0) || (n == 1)));
    if (!lrck_prev && spk.audio_lrck && lrck_rise_n < 0) lrck_rise_n = n;
    lrck_prev = spk.audio_lrck;
    if (c == 0) exp_q.push_back(cap);
    s = c / 16;
    if (c % 16 == 0) sdin_start = spk.audio_sdin;
    if (c % 16 == 8) begin
      chk("sdin_stable", 32'(spk.audio_sdin), 32'(sdin_start));
      if (s == 0) begin
        if (n < 512) begin
          chk("slot0_after_reset", 32'(spk.audio_sdin), 32'd0);
        end else begin
          dec[0] = spk.audio_sdin;
          chk("frame_queue", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("frame_lr", dec, exp_q.pop_front());
        end
      end else begin
        dec[32-s] = spk.audio_sdin;
      end
    end
  endtask

  // Called just after a posedge: assert reset mid-cycle, hold 3 clk, release mid-cycle.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_mclk", 32'(spk.audio_mclk),  32'd0);
    chk("rst_sck",  32'(spk.audio_sck),   32'd0);
    chk("rst_lrck", 32'(spk.audio_lrck),  32'd0);
    chk("rst_sdin", 32'(spk.audio_sdin),  32'd0);
    chk("rst_tick", 32'(spk.sample_tick), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_lrck", 32'(spk.audio_lrck),  32'd0);
    chk("rst_hold_sdin", 32'(spk.audio_sdin),  32'd0);
    chk("rst_hold_tick", 32'(spk.sample_tick), 32'd0);
    rst         = 1'b1;
    n           = 0;
    lrck_prev   = 1'b0;
    lrck_rise_n = -1;
    sdin_start  = 1'b0;
    dec         = '0;
    exp_q.delete();
    exp_q.push_back(32'h0);  // hold registers are cleared, first frame is silent
  endtask

  initial begin
    int k;
    drive(16'h0, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    apply_reset();

    // Clock taps and frame ticks over four frames of silence.
    repeat (2048) step();
    chk("lrck_first_rise", 32'(lrck_rise_n), 32'd256);

    // Asymmetric left/right pair held for two frames.
    drive(16'hE000, 16'h2000, 1'b0);
    repeat (1024) step();

    // Right LSB only: shows up in slot 0 of the following frame.
    drive(16'h0000, 16'h0001, 1'b0);
    repeat (512) step();
    drive(16'h0000, 16'h0000, 1'b0);
    repeat (1024) step();

    // Mid-frame input change only affects the next frame.
    drive(16'h1234, 16'h0000, 1'b0);
    repeat (512) step();
    repeat (100) step();
    drive(16'hFFFF, 16'h0000, 1'b0);
    repeat (412) step();
    repeat (512) step();

    // Mute asserted mid-frame after an all-ones right sample.
    drive(16'h0000, 16'hFFFF, 1'b0);
    repeat (512) step();
    repeat (300) step();
    drive(16'h0000, 16'hFFFF, 1'b1);
    repeat (212 + 1024) step();

    // Random samples, random mute, changed at a random point in each frame.
    for (int f = 0; f < 8; f++) begin
      k = $urandom_range(1, 510);
      drive(sample_t'($urandom), sample_t'($urandom), ($urandom_range(0, 3) == 0));
      repeat (k) step();
      drive(sample_t'($urandom), sample_t'($urandom), ($urandom_range(0, 3) == 0));
      repeat (512 - k) step();
    end

    // Reset in the middle of a frame with live inputs; the next frame must be silent.
    drive(sample_t'($urandom), 16'h0001, 1'b0);
    repeat (300) step();
    apply_reset();
    repeat (1024 + 16) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
